// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared widths, defaults and helpers for the fetch stage
package fetch_unit_pkg;

    localparam int          FETCH_ADDR_W = 12;
    localparam int          FETCH_INSN_W = 32;
    localparam int          FETCH_DEPTH  = 2;
    localparam logic [31:0] FETCH_NOP    = 32'h0000_0000;

    // Occupancy counter must represent 0..DEPTH inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - PC register, imem, redirect and decode-side signals of the fetch stage
interface fetch_unit_if
    import fetch_unit_pkg::*;
#(
    parameter int ADDR_W = FETCH_ADDR_W,
    parameter int INSN_W = FETCH_INSN_W,
    parameter int DEPTH  = FETCH_DEPTH
);
    localparam int CNT_W = cnt_width(DEPTH);

    logic [ADDR_W-1:0] pc_cur;
    logic [ADDR_W-1:0] pc_next;
    logic              pc_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [INSN_W-1:0] imem_rdata;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_target;
    logic              insn_valid;
    logic [INSN_W-1:0] insn;
    logic [ADDR_W-1:0] insn_pc;
    logic              insn_ready;
    logic [CNT_W-1:0]  queue_count;

    modport master (
        input  pc_cur, imem_rdata, redirect_valid, redirect_target, insn_ready,
        output pc_next, pc_we, imem_addr, insn_valid, insn, insn_pc, queue_count
    );

    modport slave (
        output pc_cur, imem_rdata, redirect_valid, redirect_target, insn_ready,
        input  pc_next, pc_we, imem_addr, insn_valid, insn, insn_pc, queue_count
    );

endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - synchronous FIFO holding fetched {insn, pc} entries with flush
module fetch_queue
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = FETCH_DEPTH,
    parameter int W     = FETCH_INSN_W + FETCH_ADDR_W
) (
    input  logic                        clock,
    input  logic                        ctrl_reset,
    input  logic                        push,
    input  logic [W-1:0]                push_data,
    input  logic                        pop,
    input  logic                        flush,
    output logic                        head_valid,
    output logic [W-1:0]                head_data,
    output logic [cnt_width(DEPTH)-1:0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = cnt_width(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    // A push into a full queue is accepted only when the head leaves in the same cycle.
    always_comb begin
        pop_ok  = pop & (count != '0);
        push_ok = push & ((count != DEPTH_C) | pop_ok);
    end

    assign head_valid = (count != '0);
    assign head_data  = mem[rd_ptr];

    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch: PC stepping, imem issue, redirect flush, decode queue
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int ADDR_W = FETCH_ADDR_W,
    parameter int INSN_W = FETCH_INSN_W,
    parameter int DEPTH  = FETCH_DEPTH
) (
    input  logic         clock,
    input  logic         ctrl_reset,
    fetch_unit_if.master bus
);
    localparam int CNT_W = cnt_width(DEPTH);
    localparam logic [CNT_W:0] DEPTH_L = (CNT_W+1)'(DEPTH);

    logic                     inflight;
    logic [ADDR_W-1:0]        tag;
    logic [CNT_W-1:0]         count;
    logic                     head_valid;
    logic [INSN_W+ADDR_W-1:0] head_data;
    logic                     pop;
    logic                     issue;
    logic                     push;
    logic [CNT_W:0]           occ;

    // Occupancy counts the word still in flight so the queue can never overflow.
    always_comb begin
        pop   = head_valid & bus.insn_ready;
        occ   = {1'b0, count} + (CNT_W+1)'(inflight) - (CNT_W+1)'(pop);
        issue = !ctrl_reset & !bus.redirect_valid & (occ < DEPTH_L);
        push  = inflight & !bus.redirect_valid;
    end

    assign bus.imem_addr = bus.pc_cur;
    assign bus.pc_next   = bus.redirect_valid ? bus.redirect_target : bus.pc_cur + ADDR_W'(1);
    assign bus.pc_we     = !ctrl_reset & (bus.redirect_valid | issue);

    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            inflight <= 1'b0;
            tag      <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                tag <= bus.pc_cur;
            end
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH),
        .W     (INSN_W + ADDR_W)
    ) u_queue (
        .clock      (clock),
        .ctrl_reset (ctrl_reset),
        .push       (push),
        .push_data  ({bus.imem_rdata, tag}),
        .pop        (pop),
        .flush      (bus.redirect_valid),
        .head_valid (head_valid),
        .head_data  (head_data),
        .count      (count)
    );

    assign bus.insn_valid           = head_valid;
    assign {bus.insn, bus.insn_pc}  = head_data;
    assign bus.queue_count          = count;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - vector table plus scoreboarded stream for fetch_unit
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam int AW    = 12;
    localparam int IW    = 32;
    localparam int DEPTH = 2;

    logic clock      = 1'b0;
    logic ctrl_reset = 1'b1;

    always #5 clock = ~clock;

    fetch_unit_if #(.ADDR_W(AW), .INSN_W(IW), .DEPTH(DEPTH)) bus ();

    fetch_unit #(.ADDR_W(AW), .INSN_W(IW), .DEPTH(DEPTH)) dut (
        .clock      (clock),
        .ctrl_reset (ctrl_reset),
        .bus        (bus)
    );

    function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
        return {8'h5A, 12'h000, a};
    endfunction

    logic [AW-1:0] pc_reg;
    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset)      pc_reg <= '0;
        else if (bus.pc_we)  pc_reg <= bus.pc_next;
    end
    assign bus.pc_cur = pc_reg;

    always_ff @(posedge clock) begin
        bus.imem_rdata <= mem_word(bus.imem_addr);
    end

    int errors = 0;
    int checks = 0;
    logic [AW-1:0] exp_q [$];

    typedef struct {
        logic          rdy;
        logic          redir;
        logic [AW-1:0] tgt;
        logic          we;
        logic [AW-1:0] nxt;
        logic          vld;
        logic [AW-1:0] ipc;
        logic [1:0]    cnt;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rdy, input logic redir, input logic [AW-1:0] tgt);
        bus.insn_ready      = rdy;
        bus.redirect_valid  = redir;
        bus.redirect_target = tgt;
    endtask

    task automatic refill(input logic [AW-1:0] start);
        exp_q.delete();
        for (int i = 0; i < 24; i++) exp_q.push_back(start + AW'(i));
    endtask

    task automatic sb_pop();
        logic [AW-1:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_empty: got pc %0h expected none", bus.insn_pc);
        end else begin
            e = exp_q.pop_front();
            chk("sb_pc", 32'(bus.insn_pc), 32'(e));
            chk("sb_insn", bus.insn, mem_word(e));
        end
    endtask

    task automatic apply_reset();
        ctrl_reset = 1'b1;
        drive(1'b0, 1'b0, '0);
        repeat (2) @(negedge clock);
        #1;
        chk("rst_valid", 32'(bus.insn_valid), 32'd0);
        chk("rst_we",    32'(bus.pc_we),      32'd0);
        chk("rst_count", 32'(bus.queue_count), 32'd0);
        chk("rst_insn",  bus.insn,            32'd0);
        chk("rst_pc",    32'(bus.insn_pc),    32'd0);
    endtask

    initial begin
        int first_valid;
        int npops;
        logic rdy;
        logic redir;
        logic [AW-1:0] tgt;

        vecs[0]  = '{1'b0, 1'b0, 12'h000, 1'b1, 12'h001, 1'b0, 12'h000, 2'd0};
        vecs[1]  = '{1'b0, 1'b0, 12'h000, 1'b1, 12'h002, 1'b0, 12'h000, 2'd0};
        vecs[2]  = '{1'b0, 1'b0, 12'h000, 1'b0, 12'h003, 1'b1, 12'h000, 2'd1};
        vecs[3]  = '{1'b0, 1'b0, 12'h000, 1'b0, 12'h003, 1'b1, 12'h000, 2'd2};
        vecs[4]  = '{1'b0, 1'b0, 12'h000, 1'b0, 12'h003, 1'b1, 12'h000, 2'd2};
        vecs[5]  = '{1'b0, 1'b1, 12'h100, 1'b1, 12'h100, 1'b1, 12'h000, 2'd2};
        vecs[6]  = '{1'b0, 1'b0, 12'h000, 1'b1, 12'h101, 1'b0, 12'h000, 2'd0};
        vecs[7]  = '{1'b0, 1'b0, 12'h000, 1'b1, 12'h102, 1'b0, 12'h000, 2'd0};
        vecs[8]  = '{1'b0, 1'b0, 12'h000, 1'b0, 12'h103, 1'b1, 12'h100, 2'd1};
        vecs[9]  = '{1'b1, 1'b0, 12'h000, 1'b1, 12'h103, 1'b1, 12'h100, 2'd2};
        vecs[10] = '{1'b1, 1'b0, 12'h000, 1'b1, 12'h104, 1'b1, 12'h101, 2'd1};

        // Stall from reset, fill, redirect out of a full queue, then drain.
        apply_reset();
        for (int i = 0; i < 11; i++) begin
            @(negedge clock);
            if (i == 0) ctrl_reset = 1'b0;
            drive(vecs[i].rdy, vecs[i].redir, vecs[i].tgt);
            #1;
            chk($sformatf("v%0d_we", i),    32'(bus.pc_we),       32'(vecs[i].we));
            chk($sformatf("v%0d_next", i),  32'(bus.pc_next),     32'(vecs[i].nxt));
            chk($sformatf("v%0d_valid", i), 32'(bus.insn_valid),  32'(vecs[i].vld));
            chk($sformatf("v%0d_count", i), 32'(bus.queue_count), 32'(vecs[i].cnt));
            if (vecs[i].vld) begin
                chk($sformatf("v%0d_ipc", i),  32'(bus.insn_pc), 32'(vecs[i].ipc));
                chk($sformatf("v%0d_insn", i), bus.insn,         mem_word(vecs[i].ipc));
            end
        end

        // Streaming with redirects in flight, PC wrap, random back-pressure.
        apply_reset();
        refill('0);
        first_valid = -1;
        npops = 0;
        for (int c = 0; c < 27; c++) begin
            @(negedge clock);
            if (c == 0) ctrl_reset = 1'b0;
            rdy   = (c >= 18 && c <= 25) ? 1'($urandom_range(0, 1)) : 1'b1;
            redir = (c == 8) || (c == 16);
            tgt   = (c == 8) ? 12'h2A0 : 12'hFFF;
            drive(rdy, redir, tgt);
            #1;
            if (bus.insn_valid && first_valid < 0) first_valid = c;
            if (bus.insn_valid && rdy) begin
                sb_pop();
                if (c >= 2 && c <= 7) npops++;
            end
            if (c == 8) begin
                chk("redir_next", 32'(bus.pc_next), 32'h2A0);
                chk("redir_we",   32'(bus.pc_we),   32'd1);
            end
            if (redir) refill(tgt);
            if (c == 17) begin
                chk("wrap_addr", 32'(bus.imem_addr), 32'hFFF);
                chk("wrap_next", 32'(bus.pc_next),   32'h000);
                chk("wrap_we",   32'(bus.pc_we),     32'd1);
            end
        end
        chk("first_valid", 32'(first_valid), 32'd2);
        chk("throughput",  32'(npops),       32'd6);

        // Reset asserted between edges while a fetch is in flight.
        #2 ctrl_reset = 1'b1;
        #1;
        chk("midrst_valid", 32'(bus.insn_valid),  32'd0);
        chk("midrst_we",    32'(bus.pc_we),       32'd0);
        chk("midrst_count", 32'(bus.queue_count), 32'd0);

        refill('0);
        first_valid = -1;
        for (int c = 0; c < 7; c++) begin
            @(negedge clock);
            if (c == 0) ctrl_reset = 1'b0;
            drive(1'b1, 1'b0, '0);
            #1;
            if (bus.insn_valid && first_valid < 0) first_valid = c;
            if (bus.insn_valid) sb_pop();
        end
        chk("first_valid2", 32'(first_valid), 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
